// File: rtl/width_trans_pkg.sv
`default_nettype none
// ============================================================================
// Module      : width_trans_pkg
// Description : Shared helpers for the width-converting FIFO blocks:
//               fill-counter width derivation and lane index arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
package width_trans_pkg;

    // Ceiling log2 for elaboration-time width derivation (clog2(1) == 0).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Bit offset of lane 'lane' in a packed word of 'lane_w'-bit lanes.
    function automatic int lane_lo(input int lane, input int lane_w);
        return lane * lane_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_packer_if
// Description : FIFO read port plus packed-output valid/ready bundle for
//               fifo_rd_packer. master = packer side, slave = FIFO/sink side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_rd_packer_if
    import width_trans_pkg::*;
#(
    parameter int RDDATA_SIZE = 3,
    parameter int PACK_NUM    = 4,
    parameter int OUT_SIZE    = RDDATA_SIZE * PACK_NUM,
    parameter int CNT_W       = clog2(PACK_NUM + 1)
);
    logic                   empty;
    logic [RDDATA_SIZE-1:0] rdata;
    logic                   rd_req;
    logic                   flush;
    logic [OUT_SIZE-1:0]    out_data;
    logic [CNT_W-1:0]       out_cnt;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        input  empty, rdata, flush, out_ready,
        output rd_req, out_data, out_cnt, out_valid
    );

    modport slave (
        output empty, rdata, flush, out_ready,
        input  rd_req, out_data, out_cnt, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_packer_pack_accum.sv
`default_nettype none
// ============================================================================
// Module      : pack_accum
// Description : Lane accumulator for fifo_rd_packer. Tracks the read issued
//               last cycle (pend), writes the returning FIFO word into lane
//               cnt, and clears to an all-zero, empty state on request.
// Revision    : 1.0 - initial release
// ============================================================================
module pack_accum
    import width_trans_pkg::*;
#(
    parameter int RDDATA_SIZE = 3,
    parameter int PACK_NUM    = 4,
    parameter int OUT_SIZE    = RDDATA_SIZE * PACK_NUM,
    parameter int CNT_W       = clog2(PACK_NUM + 1)
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_rd_req,
    input  wire logic                   i_clear,
    input  wire logic [RDDATA_SIZE-1:0] i_rdata,
    output logic      [OUT_SIZE-1:0]    o_acc,
    output logic      [CNT_W-1:0]       o_cnt,
    output logic                        o_pend
);
    logic [OUT_SIZE-1:0] r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_pend;
    logic [CNT_W-1:0]    w_base;

    // Lane the returning word lands in: lane 0 if the word is being emptied now.
    always_comb begin
        w_base = i_clear ? '0 : r_cnt;
    end

    // Capture returning FIFO data; clearing zeroes the lanes so partial
    // words leave with their unused lanes at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else begin
            r_pend <= i_rd_req;
            if (i_clear) begin
                r_acc <= '0;
            end
            if (r_pend) begin
                r_acc[lane_lo(int'(w_base), RDDATA_SIZE) +: RDDATA_SIZE] <= i_rdata;
                r_cnt <= w_base + 1'b1;
            end else if (i_clear) begin
                r_cnt <= '0;
            end
        end
    end

    assign o_acc  = r_acc;
    assign o_cnt  = r_cnt;
    assign o_pend = r_pend;
endmodule
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_packer
// Description : Read-side consumer of the width-converting async FIFO.
//               Pops PACK_NUM narrow words, packs them (lane 0 = oldest) into
//               one registered output word with valid/ready; flush releases
//               a partial word. Back-pressure stalls reads, nothing is lost.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_packer
    import width_trans_pkg::*;
#(
    parameter int RDDATA_SIZE = 3,
    parameter int PACK_NUM    = 4,
    parameter int OUT_SIZE    = RDDATA_SIZE * PACK_NUM,
    parameter int CNT_W       = clog2(PACK_NUM + 1)
) (
    input  wire logic         clk_rd,
    input  wire logic         rst,
    fifo_rd_packer_if.master  bus
);
    localparam logic [CNT_W-1:0] c_pack_num = CNT_W'(PACK_NUM);

    logic [OUT_SIZE-1:0] w_acc;
    logic [CNT_W-1:0]    w_cnt;
    logic                w_pend;
    logic [CNT_W:0]      w_fill;
    logic                w_rd_req;
    logic                w_out_free;
    logic                w_full_xfer;
    logic                w_part_xfer;
    logic                w_xfer;
    logic                w_flush_done;

    logic                r_flush_pend;
    logic [OUT_SIZE-1:0] r_out_data;
    logic [CNT_W-1:0]    r_out_cnt;
    logic                r_out_valid;

    pack_accum #(
        .RDDATA_SIZE (RDDATA_SIZE),
        .PACK_NUM    (PACK_NUM),
        .OUT_SIZE    (OUT_SIZE),
        .CNT_W       (CNT_W)
    ) u_pack_accum (
        .clk      (clk_rd),
        .rst      (rst),
        .i_rd_req (w_rd_req),
        .i_clear  (w_xfer),
        .i_rdata  (bus.rdata),
        .o_acc    (w_acc),
        .o_cnt    (w_cnt),
        .o_pend   (w_pend)
    );

    // Read issue, transfer and flush-completion decisions.
    // Counting the in-flight read in w_fill keeps pend low whenever cnt is full.
    always_comb begin
        w_fill       = {1'b0, w_cnt} + (CNT_W+1)'(w_pend);
        w_out_free   = !r_out_valid || bus.out_ready;
        w_rd_req     = !rst && !bus.empty && !r_flush_pend && (w_fill < {1'b0, c_pack_num});
        w_full_xfer  = (w_cnt == c_pack_num) && w_out_free;
        w_part_xfer  = r_flush_pend && !w_pend && (w_cnt != '0) &&
                       (w_cnt != c_pack_num) && w_out_free;
        w_xfer       = w_full_xfer || w_part_xfer;
        w_flush_done = r_flush_pend && !w_pend && ((w_cnt == '0) || w_xfer);
    end

    // Flush request: held until the accumulator has drained; repeats are absorbed.
    always_ff @(posedge clk_rd) begin
        if (rst) begin
            r_flush_pend <= 1'b0;
        end else if (r_flush_pend) begin
            if (w_flush_done) begin
                r_flush_pend <= 1'b0;
            end
        end else if (bus.flush) begin
            r_flush_pend <= 1'b1;
        end
    end

    // Output register: loads on transfer (possibly in the accepting cycle),
    // otherwise holds until the sink accepts.
    always_ff @(posedge clk_rd) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_cnt   <= '0;
            r_out_valid <= 1'b0;
        end else if (w_xfer) begin
            r_out_data  <= w_acc;
            r_out_cnt   <= w_cnt;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.rd_req    = w_rd_req;
    assign bus.out_data  = r_out_data;
    assign bus.out_cnt   = r_out_cnt;
    assign bus.out_valid = r_out_valid;
endmodule
`default_nettype wire
